ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter LATENCY, default 2: number of cycles the shared RAM port is held per access; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  8  per-requester access request; req[i] is held high by requester i until it sees ack[i].
REQ-005 we  input  8  per-requester write flag, valid while the matching req bit is high.
REQ-006 sel  output  3  select code for the 8:1 32-bit data/address mux feeding the RAM port; equals the index of the granted requester.
REQ-007 grant  output  8  one-hot current owner of the RAM port; all zero when idle.
REQ-008 mem_en  output  1  RAM port enable, high only while an access is in progress.
REQ-009 mem_we  output  1  RAM write enable, qualified by mem_en.
REQ-010 ack  output  8  one-hot, one-cycle completion pulse to the granted requester.
REQ-011 busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 State machine SHALL have three states: IDLE, ACCESS and DONE, with all outputs registered.
REQ-013 IDLE: if req is nonzero, the arbiter SHALL pick winner w (round-robin: first set bit scanning from ptr+1 upward modulo 8) and enter ACCESS on the next edge; otherwise it SHALL remain in IDLE.
REQ-014 On entry to ACCESS: sel=w, grant=1<<w, mem_en=1, mem_we=we[w] as sampled at the arbitration edge; wait counter loaded to LATENCY-1.
REQ-015 ACCESS SHALL last exactly LATENCY cycles, decrementing the counter each cycle, then enter DONE.
REQ-016 DONE SHALL last exactly 1 cycle: mem_en=0, mem_we=0, ack[w]=1, grant and sel held at w; ptr updated to w; then return to IDLE.
REQ-017 sel, grant and mem_we SHALL remain constant from ACCESS entry through the end of DONE; changes on req and we during that window SHALL be ignored.
REQ-018 In IDLE, grant, ack, mem_en and mem_we SHALL be 0; sel SHALL hold its last value.
REQ-019 Back-to-back operation: a request that is pending in the IDLE cycle after DONE SHALL be arbitrated in that cycle. Minimum spacing between grants is LATENCY+2 cycles.
REQ-020 Fairness: with all 8 requests held high, grants SHALL rotate 0,1,...,7,0 with no requester starved.
REQ-021 If req[w] drops during ACCESS, the access SHALL still complete and ack[w] SHALL still pulse; no abort.
REQ-022 At most one bit of grant and of ack SHALL be set at any time; ack SHALL never assert without a preceding grant to the same index.

Reset
REQ-023 While rst_n=0, asynchronously: state=IDLE, sel=0, grant=0, ack=0, mem_en=0, mem_we=0, busy=0, counter=0, ptr=7, so requester 0 has top priority first.
REQ-024 Reset asserted mid-ACCESS or mid-DONE SHALL abort the access with no ack pulse; after release the arbiter SHALL arbitrate from IDLE on the first rising edge.

Verification
REQ-025 Single request: after reset, req=8'h04, we=8'h04 -> next edge: sel=2, grant=8'h04, mem_en=1, mem_we=1 for 2 cycles; then ack=8'h04 for 1 cycle; then idle.
REQ-026 Round robin: req=8'hFF held -> grant sequence 01,02,04,...,80,01; each grant LATENCY+2=4 cycles apart.
REQ-027 Priority after ptr=3: req=8'h09 pending -> requester 3 is skipped, grant=8'h01 (scan 4..7, then 0).
REQ-028 Req drop: grant requester 5, deassert req[5] in first ACCESS cycle -> ack=8'h20 still pulses at the scheduled cycle; we change ignored, mem_we stable.
REQ-029 Reset mid-access: rst_n pulsed low during ACCESS -> all outputs 0 immediately, no ack; after release with req=8'h80 -> grant=8'h80 on the next edge.
REQ-030 LATENCY=1 build: req=8'h01 -> mem_en high exactly 1 cycle, ack on the following cycle; grant spacing 3 cycles.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among 8 requesters.
// Each access holds the port LATENCY cycles, then pulses ack for one cycle.
module ram_port_arbiter #(
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] we,
  output logic [2:0] sel,
  output logic [7:0] grant,
  output logic       mem_en,
  output logic       mem_we,
  output logic [7:0] ack,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [2:0] ptr;
  logic [2:0] win;
  logic [2:0] idx;
  logic       found;

  // First requester after the last winner, wrapping modulo 8.
  always_comb begin
    win   = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = ptr + 3'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sel    <= '0;
      grant  <= '0;
      ack    <= '0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      busy   <= 1'b0;
      cnt    <= '0;
      ptr    <= 3'd7;
    end else begin
      case (state)
        IDLE: begin
          ack <= '0;
          if (found) begin
            state  <= ACCESS;
            sel    <= win;
            grant  <= 8'b1 << win;
            mem_en <= 1'b1;
            mem_we <= we[win];
            busy   <= 1'b1;
            cnt    <= 4'(LATENCY - 1);
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            state  <= DONE;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            ack    <= grant;
            ptr    <= sel;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          ack   <= '0;
          grant <= '0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboarded bench for ram_port_arbiter: expected winners are queued when
// requests are driven and retired against grant/ack activity.
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req, we;
  logic [2:0] sel;
  logic [7:0] grant, ack;
  logic       mem_en, mem_we, busy;

  logic [7:0] req1, we1;
  logic [2:0] sel1;
  logic [7:0] grant1, ack1;
  logic       mem_en1, mem_we1, busy1;

  typedef struct {
    int   idx;
    logic wr;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;
  int   cyc  = 0;
  logic prev_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_port_arbiter #(.LATENCY(2)) u0 (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .sel(sel), .grant(grant),
    .mem_en(mem_en), .mem_we(mem_we), .ack(ack), .busy(busy)
  );

  ram_port_arbiter #(.LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .we(we1), .sel(sel1), .grant(grant1),
    .mem_en(mem_en1), .mem_we(mem_we1), .ack(ack1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Grant start and completion are retired against the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
      if (mem_en && !prev_en) begin
        if (sb.size() == 0) chk("grant_unexpected", {24'd0, grant}, 32'd0);
        else begin
          chk("grant", {24'd0, grant}, 32'd1 << sb[0].idx);
          chk("sel", {29'd0, sel}, 32'(sb[0].idx));
          chk("mem_we", {31'd0, mem_we}, {31'd0, sb[0].wr});
        end
      end
      if (ack != '0) begin
        if (sb.size() == 0) chk("ack_spurious", {24'd0, ack}, 32'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("ack", {24'd0, ack}, 32'd1 << e.idx);
          chk("ack_grant", {24'd0, grant}, 32'd1 << e.idx);
        end
      end
    end
    prev_en <= mem_en;
  end

  task automatic wait_start(output int c);
    logic p;
    bit ok;
    p = mem_en; ok = 0; c = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (mem_en && !p) begin ok = 1; c = cyc; break; end
      p = mem_en;
    end
    if (!ok) chk("start_timeout", 32'd0, 32'd1);
  endtask

  task automatic serve(input int idx, output int c);
    bit ok;
    ok = 0; c = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (ack != '0) begin ok = 1; c = cyc; req[idx] = 1'b0; we[idx] = 1'b0; break; end
    end
    if (!ok) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) step();
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int c0, c1, c, p;
    rst_n = 1'b0; req = '0; we = '0; req1 = '0; we1 = '0;
    repeat (3) step();
    chk("rst_sel", {29'd0, sel}, 32'd0);
    chk("rst_grant", {24'd0, grant}, 32'd0);
    chk("rst_ack", {24'd0, ack}, 32'd0);
    chk("rst_en", {30'd0, mem_en, mem_we}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;

    // single request
    req = 8'h04; we = 8'h04; sb.push_back('{2, 1'b1});
    wait_start(c0);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    step();
    chk("t1_en2", {31'd0, mem_en}, 32'd1);
    serve(2, c1);
    chk("t1_lat", 32'(c1 - c0), 32'd2);
    chk("t1_done_en", {30'd0, mem_en, mem_we}, 32'd0);
    step();
    chk("t1_idle_grant", {24'd0, grant}, 32'd0);
    chk("t1_idle_sel", {29'd0, sel}, 32'd2);
    chk("t1_idle_busy", {31'd0, busy}, 32'd0);
    chk("t1_idle_ack", {24'd0, ack}, 32'd0);

    // round robin with everyone requesting
    do_reset();
    req = 8'hFF; we = 8'h55;
    for (int k = 0; k < 9; k++) sb.push_back('{k % 8, ((k % 2) == 0)});
    p = 0;
    for (int k = 0; k < 9; k++) begin
      wait_start(c);
      if (k > 0) chk("rr_gap", 32'(c - p), 32'd4);
      p = c;
    end
    req = '0; we = '0;
    drain();

    // ptr=3, then 0 and 3 both pending: 0 wins
    do_reset();
    req = 8'h08; we = 8'h08; sb.push_back('{3, 1'b1});
    wait_start(c);
    serve(3, c);
    req = 8'h09; we = 8'h01;
    sb.push_back('{0, 1'b1}); sb.push_back('{3, 1'b0});
    wait_start(c);
    chk("pri_grant", {24'd0, grant}, 32'h01);
    serve(0, c);
    serve(3, c);
    step();

    // request and write flag dropped mid-access
    req = 8'h20; we = 8'h20; sb.push_back('{5, 1'b1});
    wait_start(c0);
    req = '0; we = '0;
    step();
    chk("drop_we", {31'd0, mem_we}, 32'd1);
    chk("drop_grant", {24'd0, grant}, 32'h20);
    serve(5, c1);
    chk("drop_lat", 32'(c1 - c0), 32'd2);
    step();

    // reset in the middle of an access
    req = 8'h10; we = 8'h10; sb.push_back('{4, 1'b1});
    wait_start(c);
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_grant", {24'd0, grant}, 32'd0);
    chk("mid_rst_en", {30'd0, mem_en, mem_we}, 32'd0);
    chk("mid_rst_busy_ack", {23'd0, busy, ack}, 32'd0);
    chk("mid_rst_sel", {29'd0, sel}, 32'd0);
    sb.delete();
    req = 8'h80; we = '0;
    step();
    chk("mid_rst_held", {24'd0, ack}, 32'd0);
    #2;
    rst_n = 1'b1;
    sb.push_back('{7, 1'b0});
    step();
    chk("post_rst_grant", {24'd0, grant}, 32'h80);
    serve(7, c);
    drain();

    // LATENCY=1 instance
    req1 = 8'h01; we1 = 8'h01;
    step();
    chk("l1_grant", {24'd0, grant1}, 32'h01);
    chk("l1_en", {30'd0, mem_en1, mem_we1}, 32'd3);
    step();
    chk("l1_en_off", {31'd0, mem_en1}, 32'd0);
    chk("l1_ack", {24'd0, ack1}, 32'h01);
    step();
    chk("l1_idle", {16'd0, grant1, ack1}, 32'd0);
    step();
    chk("l1_regrant", {24'd0, grant1}, 32'h01);
    req1 = '0; we1 = '0;
    step();
    chk("l1_ack2", {24'd0, ack1}, 32'h01);
    step();
    chk("l1_end", {23'd0, busy1, grant1}, 32'd0);

    step();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
